// File: rtl/ice40_top.sv
// ice40_top: WS2812-style LED strip driver with an internal frame buffer.
//
// A frame is a low latch gap of TRESET_CYC cycles followed by NUM_LEDS
// 24-bit GRB words, each sent MSB first. Every bit period is TBIT_CYC
// cycles: high for T1H_CYC (bit = 1) or T0H_CYC (bit = 0), then low for
// the rest of the period. Frames repeat back to back.
//
// Ports:
//   CLK    in   board clock, all logic on its rising edge
//   RST    in   asynchronous active-high reset
//   PIN_1  out  serial pixel data, driven straight from a flop
//   USBPU  out  USB pull-up control, tied low
//
// Optional feature: define LEDSUIT_ANIMATE_EN to rotate the frame buffer
// by one position during every latch gap that follows a frame, so the
// pattern walks along the strip. Undefined, the buffer is static.
module ice40_top #(
    parameter int NUM_LEDS   = 9,
    parameter int T0H_CYC    = 6,
    parameter int T1H_CYC    = 12,
    parameter int TBIT_CYC   = 20,
    parameter int TRESET_CYC = 1280
) (
    input  logic CLK,
    input  logic RST,
    output logic PIN_1,
    output logic USBPU
);

    localparam int CNT_MAX = (TRESET_CYC > TBIT_CYC) ? TRESET_CYC : TBIT_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int AW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    typedef enum logic [1:0] {
        LATCH    = 2'd0,
        BIT_HIGH = 2'd1,
        BIT_LOW  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [4:0]    bit_idx;
    logic [12:0]   mem_addr;
    logic [12:0]   addr_inc;
    logic [23:0]   word;
    logic [23:0]   mem [NUM_LEDS];

    logic [CW-1:0] hi_cyc;
    logic          latch_done;
    logic          high_done;
    logic          bit_done;
    logic          last_bit;
    logic          last_word;

    assign USBPU = 1'b0;

    always_comb begin
        hi_cyc     = word[bit_idx] ? CW'(T1H_CYC) : CW'(T0H_CYC);
        latch_done = (state == LATCH)    && (cnt == CW'(TRESET_CYC - 1));
        high_done  = (state == BIT_HIGH) && (cnt == (hi_cyc - CW'(1)));
        bit_done   = (state == BIT_LOW)  && (cnt == CW'(TBIT_CYC - 1));
        last_bit   = (bit_idx == 5'd0);
        last_word  = (mem_addr == 13'(NUM_LEDS - 1));
        addr_inc   = mem_addr + 13'd1;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            LATCH:    if (latch_done) state_next = BIT_HIGH;
            BIT_HIGH: if (high_done)  state_next = BIT_LOW;
            BIT_LOW: begin
                if (bit_done) begin
                    state_next = (last_bit && last_word) ? LATCH : BIT_HIGH;
                end
            end
            default:  state_next = LATCH;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= LATCH;
        end else begin
            state <= state_next;
        end
    end

    // One counter spans the whole bit period (high then low), so the low
    // phase ends at TBIT_CYC-1 regardless of which high time was used.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            bit_idx  <= 5'd0;
            mem_addr <= 13'd0;
            word     <= 24'd0;
            PIN_1    <= 1'b0;
        end else begin
            // Registering the next state keeps PIN_1 aligned with the state.
            PIN_1 <= (state_next == BIT_HIGH);
            if (latch_done) begin
                cnt      <= '0;
                mem_addr <= 13'd0;
                bit_idx  <= 5'd23;
                word     <= mem[0];
            end else if (bit_done) begin
                cnt <= '0;
                if (last_bit) begin
                    bit_idx <= 5'd23;
                    // Load the following word on the bit-0 boundary so its
                    // bit 23 starts in the very next cycle.
                    if (!last_word) begin
                        mem_addr <= addr_inc;
                        word     <= mem[addr_inc[AW-1:0]];
                    end
                end else begin
                    bit_idx <= bit_idx - 5'd1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef LEDSUIT_ANIMATE_EN
    // Set when a frame finishes; the rotation then runs on the first cycle
    // of the latch gap, long before the gap reloads word 0. The gap that
    // follows reset does not rotate, so the first frame shows the pattern.
    logic rotate_pending;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                mem[i] <= (i % 3 == 0) ? 24'h100000 :
                          (i % 3 == 1) ? 24'h001000 : 24'h000010;
            end
`ifdef LEDSUIT_ANIMATE_EN
            rotate_pending <= 1'b0;
`endif
        end
`ifdef LEDSUIT_ANIMATE_EN
        else if ((state == LATCH) && rotate_pending) begin
            for (int i = 1; i < NUM_LEDS; i++) begin
                mem[i] <= mem[i-1];
            end
            mem[0]         <= mem[NUM_LEDS-1];
            rotate_pending <= 1'b0;
        end else if (bit_done && last_bit && last_word) begin
            rotate_pending <= 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_ice40_top.sv
// tb_ice40_top: self-checking bench for ice40_top at default parameters.
// Expected pulses (rise cycle, high length) are queued when a frame is
// scheduled; a monitor measures every pulse on PIN_1 and compares it with
// the head of the queue.
module tb_ice40_top;

    localparam int N      = 9;
    localparam int TRESET = 1280;
    localparam int TBIT   = 20;
    localparam int WORDC  = 480;   // 24 * 20
    localparam int FRAME  = 5600;  // 1280 + 9 * 480

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic PIN_1;
    logic USBPU;

    ice40_top dut (
        .CLK  (CLK),
        .RST  (RST),
        .PIN_1(PIN_1),
        .USBPU(USBPU)
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Scoreboard
    int checks   = 0;
    int failures = 0;
    logic [47:0] exp_q[$];
    logic usbpu_bad = 1'b0;

    function automatic logic [23:0] pattern(input int i);
        case (i % 3)
            0:       return 24'h100000;
            1:       return 24'h001000;
            default: return 24'h000010;
        endcase
    endfunction

    function automatic logic [23:0] frame_word(input int f, input int w);
        int idx;
`ifdef LEDSUIT_ANIMATE_EN
        idx = (((w - f) % N) + N) % N;
`else
        idx = w;
`endif
        return pattern(idx);
    endfunction

    task automatic push_frame(input int base, input int f, input int nwords);
        logic [23:0] wd;
        int rise;
        int hi;
        for (int w = 0; w < nwords; w++) begin
            wd = frame_word(f, w);
            for (int b = 23; b >= 0; b--) begin
                rise = base + TRESET + f * FRAME + w * WORDC + (23 - b) * TBIT;
                hi   = wd[b] ? 12 : 6;
                exp_q.push_back({rise[31:0], hi[15:0]});
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d pulses still pending after %0d cycles, expected 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    // Monitor
    logic prev = 1'b0;
    int   rise_cyc = 0;
    always @(negedge CLK) begin
        logic [47:0] e;
        int hi;
        if (USBPU !== 1'b0) usbpu_bad = 1'b1;
        if (RST) begin
            prev = 1'b0;
        end else begin
            if (!prev && PIN_1 === 1'b1) begin
                rise_cyc = cyc;
            end else if (prev && PIN_1 !== 1'b1) begin
                hi = cyc - rise_cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse: got rise=%0d high=%0d, expected no pulse",
                             rise_cyc, hi);
                end else begin
                    e = exp_q.pop_front();
                    if (e[47:16] != rise_cyc[31:0] || e[15:0] != hi[15:0]) begin
                        failures++;
                        $display("FAIL pulse: got rise=%0d high=%0d, expected rise=%0d high=%0d",
                                 rise_cyc, hi, e[47:16], e[15:0]);
                    end
                end
            end
            prev = (PIN_1 === 1'b1);
        end
    end

    // Directed sequence
    initial begin
        int r0;
        int r1;
        int target;
        int n;

        repeat (3) @(negedge CLK);
        chk("reset_pin", PIN_1, 1'b0);
        chk("reset_usbpu", USBPU, 1'b0);

        @(negedge CLK);
        #1 RST = 1'b0;
        r0 = cyc;
        push_frame(r0, 0, N);
        push_frame(r0, 1, N);
        push_frame(r0, 2, N);
        wait_drain(3 * FRAME + 1400, "frames_0_to_2");

        // Frame 3: words 0..3 complete, then reset lands in bit 23 of word 4.
        push_frame(r0, 3, 4);
        target = r0 + TRESET + 3 * FRAME + 4 * WORDC + 2;
        n = 0;
        while (cyc != target && n < 6000) begin
            @(negedge CLK);
            n++;
        end
        chk("reached_word4", cyc, target);
        chk("word4_high_before_reset", PIN_1, 1'b1);
        chk("words_0_to_3_seen", exp_q.size(), 0);
        exp_q.delete();

        #1 RST = 1'b1;
        #1;
        chk("async_reset_pin", PIN_1, 1'b0);
        chk("async_reset_usbpu", USBPU, 1'b0);
        repeat (4) @(negedge CLK);
        chk("held_reset_pin", PIN_1, 1'b0);

        #1 RST = 1'b0;
        r1 = cyc;
        push_frame(r1, 0, N);
        wait_drain(FRAME + 400, "frame_after_reset");

        repeat (600) @(negedge CLK);
        chk("gap_low_after_frame", PIN_1, 1'b0);
        chk("usbpu_always_low", usbpu_bad, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
